// File: rtl/shift_b_sign_seq.sv
// Iterative signed-amount logical shifter: B>0 shifts A right,
// B<0 shifts A left, zero fill; one bit per clock, valid/ready handshakes.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake carrying A and B
//   A [WIDTH_A]          unsigned operand
//   B [WIDTH_B]          two's-complement shift amount
//   out_valid/out_ready  result handshake carrying Y
//   Y [WIDTH_Y]          low WIDTH_Y bits of the shift register
//   busy                 high while shifting or holding a result
module shift_b_sign_seq #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 4,
  parameter int WIDTH_Y = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_Y-1:0] Y,
  output logic               busy
);

  localparam int W    = (WIDTH_A > WIDTH_Y) ? WIDTH_A : WIDTH_Y;
  localparam int MMAX = 1 << (WIDTH_B - 1);
  localparam int CMAX = (W > MMAX) ? W : MMAX;
  // Wide enough for both W and the magnitude of the most negative B.
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_sh;
  logic [CW-1:0]   r_cnt;
  logic            r_dir;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic               w_dir;
  logic [WIDTH_B-1:0] w_mag;
  logic [CW-1:0]      w_magx;
  logic [CW-1:0]      w_cnt;

  assign w_dir  = B[WIDTH_B-1];
  // -B of the most negative value wraps to itself, which read as
  // unsigned is exactly 2^(WIDTH_B-1).
  assign w_mag  = w_dir ? -B : B;
  assign w_magx = CW'(w_mag);
  // W or more steps always empty the register, so stop at W.
  assign w_cnt  = (w_magx >= CW'(W)) ? CW'(W) : w_magx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sh       <= W'(A);
            r_dir      <= w_dir;
            r_cnt      <= w_cnt;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_cnt == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_sh  <= r_dir ? (r_sh << 1) : (r_sh >> 1);
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign Y         = r_sh[WIDTH_Y-1:0];

endmodule

// File: tb/tb_shift_b_sign_seq.sv
// Scoreboard bench for shift_b_sign_seq: an 8/4/8 instance with random
// and directed traffic, plus a 2/2/2 instance swept exhaustively.
module tb_shift_b_sign_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       in_valid0 = 1'b0, in_ready0, out_valid0, busy0;
  logic       out_ready0 = 1'b1;
  logic [7:0] a0 = '0, y0;
  logic [3:0] b0 = '0;

  logic       in_valid1 = 1'b0, in_ready1, out_valid1, busy1;
  logic       out_ready1 = 1'b1;
  logic [1:0] a1 = '0, b1 = '0, y1;

  shift_b_sign_seq #(.WIDTH_A(8), .WIDTH_B(4), .WIDTH_Y(8)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .A(a0), .B(b0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .Y(y0), .busy(busy0)
  );

  shift_b_sign_seq #(.WIDTH_A(2), .WIDTH_B(2), .WIDTH_Y(2)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .Y(y1), .busy(busy1)
  );

  typedef struct {
    int y;
    int due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic int sgn(input int b, input int wb);
    return (b >= (1 << (wb - 1))) ? b - (1 << wb) : b;
  endfunction

  // Reference: signed amount, plain shift, truncate to W then to Y.
  function automatic int ref_y(input int a, input int b,
                               input int wa, input int wb, input int wy);
    int w = (wa > wy) ? wa : wy;
    int s = sgn(b, wb);
    int v = a;
    if (s >= 0) v = v >> s;
    else        v = v << (-s);
    v = v & ((1 << w) - 1);
    return v & ((1 << wy) - 1);
  endfunction

  function automatic int ref_cnt(input int b, input int wb, input int w);
    int s = sgn(b, wb);
    int m = (s < 0) ? -s : s;
    return (m < w) ? m : w;
  endfunction

  // Returns at the falling edge after the accepting rising edge.
  task automatic send(input int sel, input int a, input int b);
    int n = 0;
    logic rdy;
    @(negedge clk);
    if (sel == 0) begin
      in_valid0 = 1'b1; a0 = 8'(a); b0 = 4'(b);
    end else begin
      in_valid1 = 1'b1; a1 = 2'(a); b1 = 2'(b);
    end
    rdy = (sel == 0) ? in_ready0 : in_ready1;
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? in_ready0 : in_ready1;
    end
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
    end else if (sel == 0) begin
      q0.push_back('{y: ref_y(a, b, 8, 4, 8),
                     due: cyc + 1 + ref_cnt(b, 4, 8)});
    end else begin
      q1.push_back('{y: ref_y(a, b, 2, 2, 2),
                     due: cyc + 1 + ref_cnt(b, 2, 2)});
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  logic pv0 = 1'b0, pv1 = 1'b0;
  int   hy0 = 0, hy1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv0 = 1'b0;
    end else begin
      if (out_valid0 && !pv0) begin
        chk("q0_pending", int'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("y0", int'(y0), e.y);
          chk("lat0", cyc, e.due);
        end
        hy0 = int'(y0);
      end else if (out_valid0) begin
        chk("y0_hold", int'(y0), hy0);
      end
      pv0 = out_valid0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv1 = 1'b0;
    end else begin
      if (out_valid1 && !pv1) begin
        chk("q1_pending", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("y1", int'(y1), e.y);
          chk("lat1", cyc, e.due);
        end
        hy1 = int'(y1);
      end else if (out_valid1) begin
        chk("y1_hold", int'(y1), hy1);
      end
      pv1 = out_valid1;
    end
  end

  logic hold = 1'b0;
  always @(negedge clk)
    if (!hold) out_ready0 = ($urandom_range(0, 3) != 0);

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready0", int'(in_ready0), 1);
    chk("rst_out_valid0", int'(out_valid0), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_y0", int'(y0), 0);
    chk("rst_in_ready1", int'(in_ready1), 1);
    chk("rst_out_valid1", int'(out_valid1), 0);

    send(0, 'hB4, 'h2);
    send(0, 'hB4, 'hD);
    send(0, 'hB4, 'h0);
    send(0, 'hB4, 'h8);
    send(0, 'h80, 'h7);

    // Backpressure: result must hold while new requests are refused.
    n = 0;
    while (q0.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    hold = 1'b1;
    out_ready0 = 1'b0;
    send(0, 'h0F, 'h1);
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", int'(out_valid0), 1);
    in_valid0 = 1'b1;
    a0 = 8'h55;
    b0 = 4'h3;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready0), 0);
      chk("bp_out_valid", int'(out_valid0), 1);
      chk("bp_busy", int'(busy0), 1);
    end
    out_ready0 = 1'b1;
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", int'(in_ready0), 1);
    chk("bp_idle_valid", int'(out_valid0), 0);
    hold = 1'b0;

    // Reset in the middle of shifting discards the result.
    send(0, 'hFF, 'h9);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", int'(in_ready0), 1);
    chk("mid_rst_out_valid", int'(out_valid0), 0);
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_y", int'(y0), 0);
    chk("mid_rst_pending", q0.size(), 1);
    q0.delete();
    repeat (12) @(negedge clk);
    send(0, 'hFF, 'h9);

    for (int i = 0; i < 40; i++) begin
      send(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) send(1, a, b);
      repeat (100) @(negedge clk);
    end

    n = 0;
    while ((q0.size() + q1.size()) > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size() + q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
